// File: rtl/fetch_sequencer_pkg.sv
// Shared CPU definitions used by the instruction fetch path: the fetch
// state encoding, address/instruction widths and the default memory timeout.
package fetch_sequencer_pkg;

  localparam int ADDR_W          = 8;
  localparam int INSTR_W         = 8;
  localparam int TIMEOUT_DEFAULT = 16;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    HOLD,
    HALTED,
    FAULT
  } fetchState_t;

endpackage

// File: rtl/fetch_sequencer_timer.sv
// Memory-response watchdog for the fetch sequencer. Counts FETCH cycles that
// passed without an ack; 'expired' flags the last cycle in which an ack is
// still accepted, so the sequencer faults if that cycle also goes unanswered.
module fetch_timer
  import fetch_sequencer_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [CNT_W-1:0] count;

  // Count ack-less cycles; saturate at the final allowed cycle.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CNT_W'(1);
    end
  end

  // count holds the number of completed ack-less cycles, so this is the
  // TIMEOUT-th FETCH cycle.
  assign expired = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: issues one program-memory read at a time,
// holds the returned byte for the controller, supports branch redirect,
// halt/resume, and a sticky fault when memory never answers.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               halt,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] instr_out,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               branch_en,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy,
  output logic               fault
);

  fetchState_t state;
  logic        haltPend;
  logic        timerClear;
  logic        timerEnable;
  logic        timerExpired;

  // The counter is held clear outside FETCH, so every FETCH entry starts at 0.
  assign timerClear  = (state != FETCH);
  assign timerEnable = (state == FETCH) && !mem_ack;

  fetch_timer #(
    .TIMEOUT (TIMEOUT)
  ) uTimer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timerClear),
    .enable  (timerEnable),
    .expired (timerExpired)
  );

  // Address bus is parked at zero whenever no request is outstanding.
  assign mem_addr = mem_req ? pc : '0;

  // Sequencer FSM; every output is registered alongside the state it belongs to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= '0;
      instr_out   <= '0;
      haltPend    <= 1'b0;
      mem_req     <= 1'b0;
      instr_valid <= 1'b0;
      busy        <= 1'b0;
      fault       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= FETCH;
            mem_req <= 1'b1;
            busy    <= 1'b1;
          end
        end

        FETCH: begin
          // A halt here only takes effect after the in-flight fetch is delivered.
          if (halt) begin
            haltPend <= 1'b1;
          end
          if (mem_ack) begin
            instr_out   <= mem_rdata;
            pc          <= pc + ADDR_W'(1);
            state       <= HOLD;
            mem_req     <= 1'b0;
            instr_valid <= 1'b1;
          end else if (timerExpired) begin
            state   <= FAULT;
            mem_req <= 1'b0;
            busy    <= 1'b0;
            fault   <= 1'b1;
          end
        end

        HOLD: begin
          if (halt) begin
            haltPend <= 1'b1;
          end
          if (instr_ready) begin
            // pc already points past this instruction; a branch replaces it.
            if (branch_en) begin
              pc <= branch_target;
            end
            instr_valid <= 1'b0;
            if (haltPend || halt) begin
              state <= HALTED;
              busy  <= 1'b0;
            end else begin
              state   <= FETCH;
              mem_req <= 1'b1;
            end
          end
        end

        HALTED: begin
          if (start) begin
            haltPend <= 1'b0;
            state    <= FETCH;
            mem_req  <= 1'b1;
            busy     <= 1'b1;
          end
        end

        FAULT: begin
          fault <= 1'b1;
        end

        default: begin
          state       <= IDLE;
          mem_req     <= 1'b0;
          instr_valid <= 1'b0;
          busy        <= 1'b0;
          fault       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 16: number of ack-less FETCH cycles before fault.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  begin or resume fetching; sampled in IDLE and HALTED only.
REQ-005 halt  input  1  stop request; sampled in FETCH and HOLD.
REQ-006 mem_req  output  1  program-memory read request.
REQ-007 mem_addr  output  8  read address; equals pc while mem_req=1, else 0.
REQ-008 mem_ack  input  1  memory has placed valid data on mem_rdata; ignored outside FETCH.
REQ-009 mem_rdata  input  8  instruction byte from memory.
REQ-010 instr_out  output  8  fetched instruction, driven to the IR input.
REQ-011 instr_valid  output  1  instr_out valid; drives the IR load request.
REQ-012 instr_ready  input  1  controller consumes instr_out this cycle.
REQ-013 branch_en  input  1  redirect pc; honoured only with instr_ready in HOLD.
REQ-014 branch_target  input  8  redirect address.
REQ-015 pc  output  8  address of the next instruction to fetch.
REQ-016 busy  output  1  high in FETCH and HOLD.
REQ-017 fault  output  1  sticky memory-timeout flag.

Function
REQ-018 FSM states SHALL be IDLE, FETCH, HOLD, HALTED and FAULT, all registered, with Moore outputs.
REQ-019 In IDLE, start=1 SHALL enter FETCH on the next edge with pc unchanged.
REQ-020 In FETCH, mem_req SHALL be 1 and mem_addr SHALL equal pc; mem_req stays high until mem_ack is sampled.
REQ-021 When mem_ack=1 is sampled in FETCH, on that edge: instr_out<=mem_rdata, pc<=pc+1 modulo 256 (0xFF wraps to 0x00), state<=HOLD, so mem_req deasserts and instr_valid asserts in the following cycle.
REQ-022 The timeout counter SHALL clear on FETCH entry and increment each FETCH cycle without mem_ack.
REQ-023 An ack arriving in the TIMEOUT-th cycle SHALL be accepted; no ack after TIMEOUT cycles SHALL enter FAULT.
REQ-024 In HOLD, instr_valid SHALL be 1 and instr_out SHALL be stable until instr_ready is sampled high.
REQ-025 On HOLD with instr_ready=1 and branch_en=1: pc<=branch_target, overriding the increment.
REQ-026 On HOLD with instr_ready=1 and branch_en=0: pc is unchanged.
REQ-027 On HOLD with instr_ready=1, the next state SHALL be HALTED if halt_pend or halt is 1, else FETCH.
REQ-028 halt sampled in FETCH SHALL set halt_pend; the fetch still completes and HOLD delivers the instruction.
REQ-029 HALTED: all handshake outputs 0, pc held; start=1 clears halt_pend and enters FETCH.
REQ-030 Simultaneous start and halt in HALTED or IDLE: start SHALL win.
REQ-031 FAULT: fault=1, mem_req=0, instr_valid=0, pc held; exit only by reset.
REQ-032 branch_en without instr_ready, or outside HOLD, SHALL have no effect.
REQ-033 At most one memory request SHALL be outstanding; instr_valid and mem_req are never high together.

Reset
REQ-034 reset=1 SHALL force state IDLE, pc=0x00, instr_out=0x00, timeout counter=0 and halt_pend=0.
REQ-035 reset=1 SHALL force mem_req, instr_valid, busy and fault to 0 from the next cycle, in any state including mid-FETCH, and any late mem_ack SHALL be ignored.

Structure
REQ-036 The shared CPU package SHALL hold the state enum, the 8-bit address and instruction width constants, and the TIMEOUT default.
REQ-037 The timeout counter SHALL be one sub-module, fetch_timer (clear, enable, expired); everything else is inline.

Verification
REQ-038 Basic fetch: reset, start pulse, ack after 2 cycles with rdata=0xA5 -> instr_valid=1, instr_out=0xA5, pc=0x01, mem_addr was 0x00.
REQ-039 Back-pressure: hold instr_ready=0 for 5 cycles -> instr_out stays 0xA5 and mem_req stays 0; ready=1 -> FETCH with mem_addr=0x01.
REQ-040 Branch and wrap: branch_target=0xFF with ready -> fetch at 0xFF, ack -> pc=0x00.
REQ-041 Timeout: no ack, TIMEOUT=16 -> fault=1 after the 16th FETCH cycle; ack on the 16th cycle instead -> no fault.
REQ-042 Halt mid-fetch: halt pulse during FETCH, ack rdata=0x3C -> 0x3C delivered, then HALTED with pc held; start -> fetch resumes at the held pc.
REQ-043 Reset mid-FETCH with mem_ack arriving 1 cycle later -> state IDLE, pc=0x00, instr_valid=0.
